root_div: RTL and testbench

ROOT_DIV -- requirements
Module: root_div

---
 rtl/root_div_pkg.sv | 17 +
 rtl/root_div_step.sv | 27 ++
 rtl/root_div.sv | 112 +++++++++++
 tb/tb_root_div.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/root_div_pkg.sv
// root_div_pkg: shared state encoding and sizing constants for the root_div divider
package root_div_pkg;

    localparam int DEF_DW = 20;
    localparam int DEF_VW = 10;

    // Wide enough for any practical DW; the top slices it down to its own width.
    localparam logic [63:0] SAT_ONES = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/root_div_step.sv
// root_div_step: one combinational restoring-division step (shift in a bit, trial subtract)
module root_div_step #(
    parameter int VW = 10
) (
    input  logic [VW:0]   rem,
    input  logic          dbit,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   rem_nxt,
    output logic          q_bit
);

    logic [VW+1:0] sh;
    logic [VW+1:0] diff;
    logic          unused_msb;

    // Shift the next dividend bit in, then keep the difference only when it did not go negative.
    always_comb begin
        sh      = {rem, dbit};
        diff    = sh - {2'b00, divisor};
        q_bit   = sh >= {2'b00, divisor};
        rem_nxt = q_bit ? diff[VW:0] : sh[VW:0];
    end

    // The incoming remainder is always below the divisor, so the top bit never carries information.
    assign unused_msb = sh[VW+1] ^ diff[VW+1];

endmodule

// File: rtl/root_div.sv
// root_div: Q10.10 by integer restoring divider; define ROOT_DIV_ROUND_EN for round-to-nearest
module root_div
    import root_div_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int VW = DEF_VW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic [VW-1:0] in_div,
    output logic          busy,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_err
);

`ifdef ROOT_DIV_ROUND_EN
    localparam int GB = 1;
    localparam int QW = DW + 1;
`else
    localparam int GB = 0;
    localparam int QW = DW - 1;
`endif
    localparam int NB = DW + GB;
    localparam int CW = $clog2(NB);

    state_t        state;
    logic [VW:0]   rem;
    logic [VW:0]   rem_nxt;
    logic          q_bit;
    logic [NB-1:0] dvd;
    logic [VW-1:0] div;
    logic [QW-1:0] q;
    logic [CW-1:0] cnt;

`ifdef ROUND_PLACEHOLDER_NEVER_DEFINED
`endif

`ifdef ROOT_DIV_ROUND_EN
    logic [DW:0] rsum;

    // Guard bit added to the truncated quotient; a carry out means saturation.
    always_comb rsum = {1'b0, q[DW:1]} + {{DW{1'b0}}, q[0]};
`endif

    root_div_step #(.VW(VW)) u_step (
        .rem     (rem),
        .dbit    (dvd[NB-1]),
        .divisor (div),
        .rem_nxt (rem_nxt),
        .q_bit   (q_bit)
    );

    // Status outputs decode straight from the state register.
    always_comb begin
        busy      = state != IDLE;
        out_valid = state == DONE;
    end

    // Sequencer: accept a request, run one quotient bit per CALC cycle, publish in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rem      <= '0;
            dvd      <= '0;
            div      <= '0;
            q        <= '0;
            cnt      <= '0;
            out_data <= '0;
            out_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    dvd     <= NB'(in_data) << GB;
                    div     <= in_div;
                    rem     <= '0;
                    q       <= '0;
                    cnt     <= '0;
                    out_err <= in_div == '0;
                    state   <= (in_div == '0) ? DONE : CALC;
                    if (in_div == '0)
                        out_data <= DW'(SAT_ONES);
                end
                CALC: begin
                    rem <= rem_nxt;
                    dvd <= dvd << 1;
                    q   <= {q[QW-2:0], q_bit};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(NB - 1)) begin
`ifdef ROOT_DIV_ROUND_EN
                        state <= ROUND;
`else
                        out_data <= {q, q_bit};
                        state    <= DONE;
`endif
                    end
                end
`ifdef ROOT_DIV_ROUND_EN
                ROUND: begin
                    out_data <= rsum[DW] ? DW'(SAT_ONES) : rsum[DW-1:0];
                    state    <= DONE;
                end
`endif
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_root_div.sv
// tb_root_div: randomized self-checking bench for root_div against a cycle-level arithmetic model
module tb_root_div;

    localparam int DW = 20;
    localparam int VW = 10;
`ifdef ROOT_DIV_ROUND_EN
    localparam int LAT = 23;
    localparam logic [DW-1:0] HALF_EXP = 20'h00001;
`else
    localparam int LAT = 21;
    localparam logic [DW-1:0] HALF_EXP = 20'h00000;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [VW-1:0] in_div = '0;
    logic          busy;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_err;

    int errs = 0;
    int checks = 0;
    bit started = 1'b0;

    root_div dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_div    (in_div),
        .busy      (busy),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Quotient the specification asks for, from plain integer arithmetic.
    function automatic logic [DW-1:0] model_q(input logic [DW-1:0] d, input logic [VW-1:0] v);
        longint x;
        if (v == 0) return '1;
`ifdef ROOT_DIV_ROUND_EN
        x = ((2 * longint'(d)) / longint'(v) + 1) / 2;
`else
        x = longint'(d) / longint'(v);
`endif
        return (x > longint'(20'hFFFFF)) ? 20'hFFFFF : DW'(x);
    endfunction

    // Model: edge counter, accept edge and the edge after which the result is visible.
    int cyc = 0;
    int acc = -10;
    int due = -10;
    logic [DW-1:0] m_q = '0;
    logic [DW-1:0] m_data = '0;
    logic          m_err = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc = -10;
            due = -10;
            m_data = '0;
            m_err = 1'b0;
        end else begin
            cyc++;
            if (in_valid && cyc >= due + 2) begin
                acc = cyc;
                m_err = in_div == 0;
                m_q = model_q(in_data, in_div);
                due = cyc + ((in_div == 0) ? 0 : LAT - 1);
            end
            if (cyc == due) m_data = m_q;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("out_valid", 32'(out_valid), 32'(cyc == due));
            chk("busy", 32'(busy), 32'(cyc >= acc && cyc <= due));
            chk("out_data", 32'(out_data), 32'(m_data));
            chk("out_err", 32'(out_err), 32'(m_err));
        end
    end

    task automatic pulse(input logic [DW-1:0] d, input logic [VW-1:0] v);
        in_valid = 1'b1;
        in_data = d;
        in_div = v;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic req_chk(input string nm, input logic [DW-1:0] d, input logic [VW-1:0] v,
                           input logic [DW-1:0] exp_d, input logic exp_e, input int exp_lat);
        int n;
        pulse(d, v);
        n = 1;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        chk({nm, "_lat"}, 32'(n), 32'(exp_lat));
        chk({nm, "_data"}, 32'(out_data), 32'(exp_d));
        chk({nm, "_err"}, 32'(out_err), 32'(exp_e));
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses;
        logic [DW-1:0] seen;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_err", 32'(out_err), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        started = 1'b1;
        @(posedge clk);
        #1;

        req_chk("ten_by_four", 20'h02800, 10'd4, 20'h00A00, 1'b0, LAT);
        req_chk("div_zero", 20'h12345, 10'd0, 20'hFFFFF, 1'b1, 1);
        req_chk("max_by_one", 20'hFFFFF, 10'd1, 20'hFFFFF, 1'b0, LAT);
        req_chk("max_by_max", 20'hFFFFF, 10'h3FF, 20'h00401, 1'b0, LAT);
        req_chk("lsb_by_two", 20'h00001, 10'd2, HALF_EXP, 1'b0, LAT);

        pulse(20'h02800, 10'd4);
        repeat (4) @(posedge clk);
        #1 pulse(20'hFFFFF, 10'd1);
        pulses = 0;
        seen = '0;
        repeat (40) begin
            if (out_valid) begin
                pulses++;
                seen = out_data;
            end
            @(posedge clk);
            #1;
        end
        chk("busy_drop_pulses", 32'(pulses), 32'd1);
        chk("busy_drop_data", 32'(seen), 32'h00A00);

        pulse(20'h02800, 10'd4);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        #1 rst = 1'b0;
        pulses = 0;
        repeat (30) begin
            @(posedge clk);
            #1 if (out_valid) pulses++;
        end
        chk("abort_no_out", 32'(pulses), 32'd0);
        req_chk("after_abort", 20'h02800, 10'd4, 20'h00A00, 1'b0, LAT);

        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 7);
            in_valid = $urandom_range(0, 9) == 0;
            in_data = ($urandom_range(0, 7) == 0) ? 20'hFFFFF : DW'($urandom);
            in_div = (r == 0) ? 10'd0 : (r == 1) ? 10'd1 : (r == 2) ? 10'h3FF :
                     (r == 3) ? VW'($urandom_range(2, 15)) : VW'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                #2 rst = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
